// File: rtl/pwm_generator_if.sv
// Configuration-to-pin bundle between the SPI register file and the PWM pin driver.
// Pure wiring, no latency; quasi-static register contents, so there is no handshake or backpressure.
interface pwm_generator_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_generator.sv
// Drives 16 pins low, static high or from one shared PWM wave; pins register 1 cycle after enables.
// Duty is shadowed per 255-tick period; no backpressure, inputs are sampled every cycle.
module pwm_generator #(
  parameter int CLK_DIV = 13
) (
  input  logic            clk,
  input  logic            rst,
  pwm_generator_if.slave  pwm_io
);

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    CNT_MAX = 8'd254;

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic [7:0]    duty_sh;
  logic          tick;
  logic          wrap;
  logic          pwm;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   out_nxt;
  logic          ps_nxt;
  logic [15:0]   out_q;
  logic          ps_q;

  always_comb begin
    en_out  = {pwm_io.en_reg_out_15_8, pwm_io.en_reg_out_7_0};
    en_pwm  = {pwm_io.en_reg_pwm_15_8, pwm_io.en_reg_pwm_7_0};
    tick    = (pre == PRE_MAX);
    wrap    = tick && (cnt == CNT_MAX);
    // cnt never reaches 255, so duty 0xFF keeps pwm high across the wrap
    pwm     = (cnt < duty_sh);
    out_nxt = en_out & (~en_pwm | {16{pwm}});
    ps_nxt  = (cnt == 8'd0) && (pre == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      cnt     <= 8'd0;
      duty_sh <= 8'd0;
      out_q   <= 16'h0000;
      ps_q    <= 1'b0;
    end else begin
      pre   <= tick ? '0 : pre + PW'(1);
      out_q <= out_nxt;
      ps_q  <= ps_nxt;
      if (wrap) begin
        cnt     <= 8'd0;
        duty_sh <= pwm_io.pwm_duty_cycle;
      end else if (tick) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign pwm_io.out          = out_q;
  assign pwm_io.period_start = ps_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: per-cycle expected pins/period_start queued at drive time and popped after the edge,
// plus high-time and period-length measurements per scenario.
module tb_pwm_generator;
  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 255 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  duty = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] sb_q[$];
  int          m_t    = 0;
  logic [7:0]  m_duty = 8'h00;

  pwm_generator_if bus ();

  assign bus.en_reg_out_7_0  = en_out[7:0];
  assign bus.en_reg_out_15_8 = en_out[15:8];
  assign bus.en_reg_pwm_7_0  = en_pwm[7:0];
  assign bus.en_reg_pwm_15_8 = en_pwm[15:8];
  assign bus.pwm_duty_cycle  = duty;

  pwm_generator #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_io (bus)
  );

  always #5 clk = ~clk;

  // Expected {out, period_start} after the coming edge, from the current inputs and the
  // time elapsed since reset release: cnt = (t / CLK_DIV) % 255, period starts at t % PERIOD == 0.
  task automatic step(output logic [16:0] exp_v, output logic [16:0] got_v);
    logic [16:0] e;
    int          cnt_m;
    logic        pw;
    e = '0;
    if (rst) begin
      m_t    = 0;
      m_duty = 8'h00;
    end else begin
      cnt_m  = (m_t / CLK_DIV) % 255;
      pw     = (cnt_m < int'(m_duty));
      e[16:1] = en_out & (~en_pwm | {16{pw}});
      e[0]    = ((m_t % PERIOD) == 0);
      if ((m_t % PERIOD) == PERIOD - 1) m_duty = duty;
      m_t++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_v = {bus.out, bus.period_start};
    exp_v = sb_q.pop_front();
  endtask

  task automatic test_reset();
    logic [16:0] e, g;
    rst = 1'b1; en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(e, g);
      n_cmp++;
      if (g !== 17'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got out=%h ps=%b, want out=0000 ps=0", i, g[16:1], g[0]);
      end
    end
    rst = 1'b0;
    step(e, g);
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_release: got out=%h ps=%b, want out=%h ps=%b", g[16:1], g[0], e[16:1], e[0]);
    end
    n_cmp++;
    if (g[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ps: got %b, want 1", g[0]);
    end
  endtask

  task automatic test_static();
    logic [16:0] e, g;
    en_out = 16'h00FF; en_pwm = 16'h0000; duty = 8'h00;
    step(e, g);
    n_cmp++;
    if (g[16:1] !== 16'h00FF || g !== e) begin
      n_fail++;
      $display("FAIL static_00ff: got out=%h, want out=%h", g[16:1], e[16:1]);
    end
    en_out = 16'hF000;
    step(e, g);
    n_cmp++;
    if (g[16:1] !== 16'hF000 || g !== e) begin
      n_fail++;
      $display("FAIL static_f000: got out=%h, want out=%h", g[16:1], e[16:1]);
    end
    for (int i = 0; i < 20; i++) begin
      en_out = 16'($urandom); en_pwm = 16'($urandom);
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL static_rand cyc%0d: got out=%h ps=%b, want out=%h ps=%b", i, g[16:1], g[0], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_duty128();
    logic [16:0] e, g;
    int pulses, hi, lo;
    int ps_at[8];
    pulses = 0; hi = 0; lo = 0;
    for (int i = 0; i < 8; i++) ps_at[i] = 0;
    rst = 1'b1; en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'd128;
    step(e, g);
    rst = 1'b0;
    for (int s = 0; s < 3 * PERIOD + 2; s++) begin
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL duty128 cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
      if (g[0] === 1'b1) begin
        if (pulses < 8) ps_at[pulses] = s;
        pulses++;
      end
      if (pulses == 2) begin
        if (g[1] === 1'b1) hi++; else lo++;
      end
    end
    n_cmp++;
    if (hi != 128 * CLK_DIV || lo != 127 * CLK_DIV) begin
      n_fail++;
      $display("FAIL duty128_shape: got hi=%0d lo=%0d, want hi=%0d lo=%0d", hi, lo, 128 * CLK_DIV, 127 * CLK_DIV);
    end
    n_cmp++;
    if (pulses < 3 || ps_at[2] - ps_at[1] != PERIOD || ps_at[1] - ps_at[0] != PERIOD) begin
      n_fail++;
      $display("FAIL duty128_period: got pulses=%0d spacing=%0d,%0d, want %0d", pulses, ps_at[1] - ps_at[0], ps_at[2] - ps_at[1], PERIOD);
    end
  endtask

  task automatic test_extremes();
    logic [16:0] e, g;
    int pulses, hi0, lo_ff;
    pulses = 0; hi0 = 0; lo_ff = 0;
    rst = 1'b1; en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h00;
    step(e, g);
    rst = 1'b0;
    for (int s = 0; s < 3 * PERIOD; s++) begin
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL duty00 cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
      if (g[1] === 1'b1) hi0++;
    end
    n_cmp++;
    if (hi0 != 0) begin
      n_fail++;
      $display("FAIL duty00_never_high: got %0d high cycles, want 0", hi0);
    end
    rst = 1'b1; duty = 8'hFF;
    step(e, g);
    rst = 1'b0;
    for (int s = 0; s < 4 * PERIOD + 2; s++) begin
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL dutyff cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
      if (g[0] === 1'b1) pulses++;
      if (pulses >= 2 && g[1] !== 1'b1) lo_ff++;
    end
    n_cmp++;
    if (lo_ff != 0 || pulses < 4) begin
      n_fail++;
      $display("FAIL dutyff_no_dip: got %0d low cycles over %0d pulses, want 0 low", lo_ff, pulses);
    end
  endtask

  task automatic test_mid_update();
    logic [16:0] e, g;
    int pulses;
    int hi[5];
    pulses = 0;
    for (int i = 0; i < 5; i++) hi[i] = 0;
    rst = 1'b1; en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'd64;
    step(e, g);
    rst = 1'b0;
    for (int s = 0; s < 3 * PERIOD + 2; s++) begin
      if (s == PERIOD + 100 * CLK_DIV) duty = 8'd192;
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL midupd cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
      if (g[0] === 1'b1) pulses++;
      if (pulses < 5 && g[1] === 1'b1) hi[pulses]++;
    end
    n_cmp++;
    if (hi[2] != 64 * CLK_DIV || hi[3] != 192 * CLK_DIV) begin
      n_fail++;
      $display("FAIL midupd_hi: got %0d then %0d, want %0d then %0d", hi[2], hi[3], 64 * CLK_DIV, 192 * CLK_DIV);
    end
  endtask

  task automatic test_mask_reset();
    logic [16:0] e, g;
    int first_ps, second_ps;
    first_ps = -1; second_ps = -1;
    rst = 1'b1; en_out = 16'h0000; en_pwm = 16'hFFFF; duty = 8'hFF;
    step(e, g);
    rst = 1'b0;
    for (int s = 0; s < 50 * CLK_DIV; s++) begin
      if (s == 10) en_out = 16'hFFFF;
      if (s == 5 || s == PERIOD) en_out = 16'h0000;
      step(e, g);
      n_cmp++;
      if (g !== e || (s < 10 && g[16:1] !== 16'h0000)) begin
        n_fail++;
        $display("FAIL mask cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
    end
    en_out = 16'hFFFF; en_pwm = 16'h00FF;
    step(e, g);
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL mask_enable: got out=%h, want out=%h", g[16:1], e[16:1]);
    end
    rst = 1'b1;
    step(e, g);
    n_cmp++;
    if (g !== 17'h0) begin
      n_fail++;
      $display("FAIL midreset_edge: got out=%h ps=%b, want out=0000 ps=0", g[16:1], g[0]);
    end
    rst = 1'b0;
    for (int s = 0; s < PERIOD + 5; s++) begin
      step(e, g);
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL postreset cyc%0d: got out=%h ps=%b, want out=%h ps=%b", s, g[16:1], g[0], e[16:1], e[0]);
      end
      if (g[0] === 1'b1) begin
        if (first_ps < 0) first_ps = s;
        else if (second_ps < 0) second_ps = s;
      end
    end
    n_cmp++;
    if (first_ps != 0 || second_ps - first_ps != PERIOD) begin
      n_fail++;
      $display("FAIL postreset_period: got first=%0d second=%0d, want first=0 second=%0d", first_ps, second_ps, PERIOD);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty128();
    test_extremes();
    test_mid_update();
    test_mask_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Downstream consumer of the SPI register file: turns the five configuration bytes written over SPI into 16 output pins. Each pin is forced low, held static high, or driven by one shared PWM waveform. A clock prescaler and an 8-bit period counter produce that waveform. A duty shadow register makes duty updates take effect only at period boundaries, so no pulse is ever truncated.

## Interface
- CLK_DIV, 13, prescaler divide ratio, legal range 1..65535. PWM frequency = f_clk / (CLK_DIV × 255); with a 10 MHz clock this is about 3.0 kHz.
- clk  input  1  system clock; single clock domain, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en_reg_out_7_0  input  8  output enable, pins 7..0.
- en_reg_out_15_8  input  8  output enable, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8.
- pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %.
- out  output  16  pin drive, registered.
- period_start  output  1  one-cycle pulse on the first clock of each PWM period, registered.

## Operation
- Concatenations used below:
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}
  - en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}
- Prescaler `pre`: width max(1, clog2(CLK_DIV)).
  - Counts 0..CLK_DIV−1 and wraps to 0.
  - `tick` = (pre == CLK_DIV−1). With CLK_DIV = 1, tick is asserted every cycle.
- Period counter `cnt`, 8-bit unsigned:
  - On tick it increments by 1.
  - At 254 it wraps to 0, so the period is 255 ticks (values 0..254). The value 255 is never reached.
- Duty shadow `duty_sh`, 8-bit:
  - Loaded with pwm_duty_cycle on the tick where cnt wraps 254→0.
  - Holds its value at all other times.
  - Input changes mid-period are ignored until the next wrap.
- PWM level: pwm = (cnt < duty_sh), unsigned compare.
  - duty_sh = 0: pwm is always 0.
  - duty_sh = 255: pwm is always 1, with no low sample at the wrap.
  - High time per period = duty_sh × CLK_DIV clocks.
- Pin function, for each bit i:
  - en_out[i] = 0: out[i] = 0, regardless of en_pwm[i].
  - en_out[i] = 1 and en_pwm[i] = 0: out[i] = 1.
  - en_out[i] = 1 and en_pwm[i] = 1: out[i] = pwm.
- Enables are not shadowed. A change takes effect on the next clock edge.
- period_start is asserted for the single cycle in which the registered cnt is 0 and pre is 0.
- Reset values (rst high at a clock edge): pre = 0, cnt = 0, duty_sh = 0, out = 16'h0000, period_start = 0.
- Consequence of the reset values: the first period after reset is always low on PWM pins. The first programmed duty applies from the second period.

## Timing
- All state updates on the rising edge of clk. rst takes priority over every other update.
- out latency: out at edge n+1 reflects en_out, en_pwm, cnt and duty_sh as they were before edge n+1. Enable-to-pin latency is 1 cycle.
- Duty latency: a new pwm_duty_cycle appears on the pins at the start of the next period, between 1 and 255×CLK_DIV cycles after it is applied.
- Period boundary sequence, from the tick with cnt = 254:
  - The next edge sets cnt = 0, pre = 0 and duty_sh = new value.
  - The edge after that registers out using the new duty and asserts period_start.
- Simultaneous pwm_duty_cycle change and wrap tick: the value present on that tick's cycle is captured.
- Reset mid-period:
  - out = 0 and period_start = 0 on the edge where rst is sampled high.
  - Counters restart from 0 on the first edge after rst goes low.
  - The period in progress is discarded.
- No handshake on the inputs. They are quasi-static SPI register contents, already in the clk domain.

## Test plan
- Reset: rst = 1 for 3 cycles with all inputs 0xFF -> out = 0x0000 and period_start = 0 throughout; cnt = 0 and pre = 0 on release.
- Static drive: en_out = 0x00FF, en_pwm = 0x0000 -> out = 0x00FF one cycle later; change en_out to 0xF000 -> out = 0xF000 one cycle later.
- Duty 128 (CLK_DIV = 13, en_out = en_pwm = 0x0001, measured from the second period) -> out[0] high for 1664 cycles and low for 1651 cycles; period_start every 3315 cycles.
- Extremes: duty 0x00 -> out[0] never high over 3 periods; duty 0xFF -> out[0] constant 1 across wraps, no single-cycle dip.
- Mid-period update: duty 64, change to 192 at cnt = 100 -> current period high for 64×13 cycles, next period high for 192×13 cycles.
- Masking and reset: en_pwm = 0xFFFF with en_out = 0x0000 -> out = 0; assert rst at cnt = 50 -> out = 0 on that edge, and the next period_start occurs 255×13 cycles after release.
